vram_arbiter: RTL and testbench

- Shares one single-port, synchronous-read VRAM (1-cycle read latency) between the tile renderer's fetch port and the CPU.
- The VDP always wins a slot so the renderer keeps fixed latency. CPU writes are posted through a small write buffer, and CPU reads use a request/ack handshake.
- Sits between the VDP top level, the CPU bus interface and the VRAM macro.

---
 rtl/vram_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Purpose: shares one single-port, synchronous-read VRAM between the tile renderer and the CPU.
// Latency: VDP read data 1 cycle after request; CPU read ack at earliest 2 cycles after the
//          request is sampled; posted CPU writes drain in FIFO order whenever the VDP is idle.
// Backpressure: the VDP is never stalled; CPU writes stall on o_cpu_wr_ready while the buffer is
//               full; CPU reads wait until the VDP is idle and every buffered write has drained.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-low reset
//   i_vdp_req/i_vdp_addr    renderer read request (always wins the slot)
//   o_vdp_rdata/o_vdp_rvalid renderer read data (straight from VRAM) and its valid, 1 cycle later
//   i_cpu_wr_*              CPU posted-write offer; o_cpu_wr_ready = buffer not full
//   i_cpu_rd_req/addr       CPU read request, level, held until o_cpu_rd_ack
//   o_cpu_rd_ack/data       one-cycle ack pulse, data held until the next ack
//   o_mem_*/i_mem_rdata     VRAM macro port (read data one cycle after address)
//   i_starve_clr            clears o_starve_flag
//   o_starve_flag           sticky: CPU went STARVE_LIMIT consecutive cycles unserved
//   o_wbuf_level            number of buffered writes

module vram_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int WBUF_DEPTH   = 4,
  parameter int STARVE_LIMIT = 1023,
  localparam int PTR_W       = $clog2(WBUF_DEPTH),
  localparam int LVL_W       = PTR_W + 1,
  localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_vdp_req,
  input  logic [ADDR_W-1:0] i_vdp_addr,
  output logic [7:0]        o_vdp_rdata,
  output logic              o_vdp_rvalid,
  input  logic              i_cpu_wr_req,
  input  logic [ADDR_W-1:0] i_cpu_wr_addr,
  input  logic [7:0]        i_cpu_wr_data,
  output logic              o_cpu_wr_ready,
  input  logic              i_cpu_rd_req,
  input  logic [ADDR_W-1:0] i_cpu_rd_addr,
  output logic              o_cpu_rd_ack,
  output logic [7:0]        o_cpu_rd_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [7:0]        o_mem_wdata,
  input  logic [7:0]        i_mem_rdata,
  input  logic              i_starve_clr,
  output logic              o_starve_flag,
  output logic [LVL_W-1:0]  o_wbuf_level
);

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_DATA = 2'd2,
    RD_DONE = 2'd3
  } rd_state_t;

  rd_state_t r_rd_state;
  rd_state_t w_rd_state_nxt;

  // write buffer
  logic [ADDR_W-1:0] r_wb_addr [WBUF_DEPTH];
  logic [7:0]        r_wb_data [WBUF_DEPTH];
  logic [PTR_W-1:0]  r_wb_wptr;
  logic [PTR_W-1:0]  r_wb_rptr;
  logic [LVL_W-1:0]  r_wb_count;
  logic              w_wb_full;
  logic              w_wb_empty;
  logic              w_wb_push;
  logic              w_wb_pop;

  // read path
  logic              w_rd_wait;
  logic              w_rd_data;
  logic              w_rd_slot;
  logic              r_cpu_rd_ack;
  logic [7:0]        r_cpu_rd_data;

  logic              r_vdp_rvalid;

  // starvation monitor
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [CNT_W-1:0]  w_starve_cnt_nxt;
  logic              r_starve_flag;
  logic              w_starve_set;
  logic              w_cpu_pending;
  logic              w_cpu_grant;

  // ---------------------------------------------------------------------------
  // Write buffer. Full is judged on the registered count, so a write offered
  // while full is refused even if the head drains in the same cycle.
  // ---------------------------------------------------------------------------
  assign w_wb_full  = (r_wb_count == LVL_W'(WBUF_DEPTH));
  assign w_wb_empty = (r_wb_count == '0);
  assign w_wb_push  = i_cpu_wr_req & ~w_wb_full;
  assign w_wb_pop   = ~i_vdp_req & ~w_wb_empty;

  always_ff @(posedge i_clk) begin
    if (w_wb_push) begin
      r_wb_addr[r_wb_wptr] <= i_cpu_wr_addr;
      r_wb_data[r_wb_wptr] <= i_cpu_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wb_wptr  <= '0;
      r_wb_rptr  <= '0;
      r_wb_count <= '0;
    end else begin
      if (w_wb_push) r_wb_wptr <= r_wb_wptr + PTR_W'(1);
      if (w_wb_pop)  r_wb_rptr <= r_wb_rptr + PTR_W'(1);
      case ({w_wb_push, w_wb_pop})
        2'b10:   r_wb_count <= r_wb_count + LVL_W'(1);
        2'b01:   r_wb_count <= r_wb_count - LVL_W'(1);
        default: r_wb_count <= r_wb_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // CPU read FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_rd_state <= RD_IDLE;
    else          r_rd_state <= w_rd_state_nxt;
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      RD_IDLE: if (i_cpu_rd_req) w_rd_state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (!i_cpu_rd_req)  w_rd_state_nxt = RD_IDLE;
        else if (w_rd_slot) w_rd_state_nxt = RD_DATA;
      end
      RD_DATA: w_rd_state_nxt = RD_DONE;
      // DONE ignores a still-high request so the same read is not issued twice
      RD_DONE: w_rd_state_nxt = RD_IDLE;
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    w_rd_wait = (r_rd_state == RD_WAIT);
    w_rd_data = (r_rd_state == RD_DATA);
  end

  // The read only gets the port once the buffer is empty, which keeps
  // read-after-write ordering for the CPU.
  assign w_rd_slot = w_rd_wait & i_cpu_rd_req & ~i_vdp_req & w_wb_empty;

  // mem_rdata for the read slot arrives during RD_DATA; capture it together
  // with the ack so data and ack become visible in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cpu_rd_ack  <= 1'b0;
      r_cpu_rd_data <= 8'h00;
    end else begin
      r_cpu_rd_ack <= w_rd_data;
      if (w_rd_data) r_cpu_rd_data <= i_mem_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot selection: VDP, then buffered write, then CPU read, else idle VDP addr
  // ---------------------------------------------------------------------------
  always_comb begin
    o_mem_addr  = i_vdp_addr;
    o_mem_we    = 1'b0;
    o_mem_wdata = r_wb_data[r_wb_rptr];
    if (!i_vdp_req) begin
      if (!w_wb_empty) begin
        o_mem_addr = r_wb_addr[r_wb_rptr];
        o_mem_we   = 1'b1;
      end else if (w_rd_slot) begin
        o_mem_addr = i_cpu_rd_addr;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_vdp_rvalid <= 1'b0;
    else          r_vdp_rvalid <= i_vdp_req;
  end

  // ---------------------------------------------------------------------------
  // Starvation monitor. A cycle with no CPU work breaks the run of unserved
  // cycles, so the counter restarts from zero as it does on a grant.
  // ---------------------------------------------------------------------------
  assign w_cpu_pending = ~w_wb_empty | w_rd_wait;
  assign w_cpu_grant   = w_wb_pop | w_rd_slot;

  always_comb begin
    w_starve_cnt_nxt = '0;
    if (!w_cpu_grant && w_cpu_pending) begin
      if (r_starve_cnt == CNT_W'(STARVE_LIMIT)) w_starve_cnt_nxt = r_starve_cnt;
      else                                      w_starve_cnt_nxt = r_starve_cnt + CNT_W'(1);
    end
  end

  // Set is evaluated on the next count so the flag rises on the same edge the
  // counter reaches the limit; while saturated the set keeps beating a clear.
  assign w_starve_set = (w_starve_cnt_nxt == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_starve_cnt  <= '0;
      r_starve_flag <= 1'b0;
    end else begin
      r_starve_cnt  <= w_starve_cnt_nxt;
      r_starve_flag <= w_starve_set | (r_starve_flag & ~i_starve_clr);
    end
  end

  assign o_vdp_rdata    = i_mem_rdata;
  assign o_vdp_rvalid   = r_vdp_rvalid;
  assign o_cpu_wr_ready = ~w_wb_full;
  assign o_cpu_rd_ack   = r_cpu_rd_ack;
  assign o_cpu_rd_data  = r_cpu_rd_data;
  assign o_starve_flag  = r_starve_flag;
  assign o_wbuf_level   = r_wb_count;

endmodule

// File: tb/tb_vram_arbiter.sv
// Purpose: self-checking bench for vram_arbiter with a transaction-level reference model.
// Latency: every cycle is compared shortly after the falling edge, away from the active edge.
// Backpressure: CPU stimulus honours cpu_wr_ready and the level/ack read handshake.

module tb_vram_arbiter;
  localparam int AW    = 14;
  localparam int DEPTH = 4;
  localparam int LIM   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vdp_req;
  logic [AW-1:0] vdp_addr;
  logic [7:0]    vdp_rdata;
  logic          vdp_rvalid;
  logic          cpu_wr_req;
  logic [AW-1:0] cpu_wr_addr;
  logic [7:0]    cpu_wr_data;
  logic          cpu_wr_ready;
  logic          cpu_rd_req;
  logic [AW-1:0] cpu_rd_addr;
  logic          cpu_rd_ack;
  logic [7:0]    cpu_rd_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          starve_clr;
  logic          starve_flag;
  logic [2:0]    wbuf_level;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .WBUF_DEPTH(DEPTH), .STARVE_LIMIT(LIM)) u_dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_vdp_req(vdp_req), .i_vdp_addr(vdp_addr),
    .o_vdp_rdata(vdp_rdata), .o_vdp_rvalid(vdp_rvalid),
    .i_cpu_wr_req(cpu_wr_req), .i_cpu_wr_addr(cpu_wr_addr), .i_cpu_wr_data(cpu_wr_data),
    .o_cpu_wr_ready(cpu_wr_ready),
    .i_cpu_rd_req(cpu_rd_req), .i_cpu_rd_addr(cpu_rd_addr),
    .o_cpu_rd_ack(cpu_rd_ack), .o_cpu_rd_data(cpu_rd_data),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .i_starve_clr(starve_clr), .o_starve_flag(starve_flag), .o_wbuf_level(wbuf_level)
  );

  // VRAM contents (environment) and the model's own view of them
  logic [7:0] vram   [0:(1<<AW)-1];
  logic [7:0] shadow [0:(1<<AW)-1];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  // reference model state
  wr_t        wq[$];
  bit         m_wait;
  int         m_busy;
  bit         m_ack;
  logic [7:0] m_rdata;
  logic [7:0] m_iss_data;
  bit         m_rvalid;
  logic [7:0] m_vdp_data;
  int         m_cnt;
  bit         m_flag;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ack_count = 0;
  int ack_cyc = 0;
  int we_count = 0;
  int peak = 0;
  bit ack_last = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    m_wait   = 0;
    m_busy   = 0;
    m_ack    = 0;
    m_rdata  = 8'h00;
    m_rvalid = 0;
    m_cnt    = 0;
    m_flag   = 0;
  endtask

  task automatic idle();
    vdp_req     = 0;
    vdp_addr    = '0;
    cpu_wr_req  = 0;
    cpu_wr_addr = '0;
    cpu_wr_data = 8'h00;
    cpu_rd_req  = 0;
    cpu_rd_addr = '0;
    starve_clr  = 0;
  endtask

  // One clock cycle: entered at a falling edge with inputs already driven.
  task automatic step();
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [7:0]    e_wd;
    bit            push, pop, issue, grant, pend, s_vdp, s_rd, s_clr;
    logic [7:0]    nx_vdp, nx_iss;
    wr_t           nw;
    logic [AW-1:0] b_addr;
    logic          b_we;
    logic [7:0]    b_wd;
    #1;
    if (!rst_n) model_reset();
    e_addr = vdp_addr;
    e_we   = 1'b0;
    e_wd   = 8'h00;
    if (!vdp_req && wq.size() > 0) begin
      e_addr = wq[0].a;
      e_we   = 1'b1;
      e_wd   = wq[0].d;
    end else if (!vdp_req && m_wait && cpu_rd_req) begin
      e_addr = cpu_rd_addr;
    end
    check("mem_addr", mem_addr, e_addr);
    check("mem_we", mem_we, e_we);
    if (e_we) check("mem_wdata", mem_wdata, e_wd);
    check("wr_ready", cpu_wr_ready, wq.size() < DEPTH);
    check("wbuf_level", wbuf_level, wq.size());
    check("rd_ack", cpu_rd_ack, m_ack);
    check("rd_data", cpu_rd_data, m_rdata);
    check("vdp_rvalid", vdp_rvalid, m_rvalid);
    if (m_rvalid) check("vdp_rdata", vdp_rdata, m_vdp_data);
    check("starve_flag", starve_flag, m_flag);
    ack_last = cpu_rd_ack;
    if (cpu_rd_ack) begin
      ack_count++;
      ack_cyc = cyc;
    end
    if (mem_we) we_count++;
    if (int'(wbuf_level) > peak) peak = int'(wbuf_level);

    push   = rst_n && cpu_wr_req && (wq.size() < DEPTH);
    pop    = rst_n && !vdp_req && (wq.size() > 0);
    issue  = rst_n && !vdp_req && (wq.size() == 0) && m_wait && cpu_rd_req;
    grant  = pop || issue;
    pend   = (wq.size() > 0) || m_wait;
    nx_vdp = shadow[e_addr];
    nx_iss = shadow[cpu_rd_addr];
    s_vdp  = vdp_req;
    s_rd   = cpu_rd_req;
    s_clr  = starve_clr;
    nw.a   = cpu_wr_addr;
    nw.d   = cpu_wr_data;
    b_addr = mem_addr;
    b_we   = mem_we;
    b_wd   = mem_wdata;

    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (pop) begin
        shadow[wq[0].a] = wq[0].d;
        void'(wq.pop_front());
      end
      if (push) wq.push_back(nw);
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 1) begin
          m_ack   = 1;
          m_rdata = m_iss_data;
        end else begin
          m_ack = 0;
        end
      end else if (m_wait) begin
        if (!s_rd) m_wait = 0;
        else if (issue) begin
          m_wait     = 0;
          m_busy     = 2;
          m_iss_data = nx_iss;
        end
      end else if (s_rd) begin
        m_wait = 1;
      end
      if (grant)     m_cnt = 0;
      else if (pend) m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
      else           m_cnt = 0;
      m_flag     = (m_cnt == LIM) || (m_flag && !s_clr);
      m_rvalid   = s_vdp;
      m_vdp_data = nx_vdp;
    end
    // synchronous-read VRAM: read-before-write, data visible after the edge
    #1;
    mem_rdata = vram[b_addr];
    if (b_we) vram[b_addr] = b_wd;
    @(negedge clk);
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int n0;
    n0 = ack_count;
    for (int k = 0; k < budget && ack_count == n0; k++) step();
    check(tag, ack_count - n0, 1);
  endtask

  initial begin
    logic [7:0] keep;
    int n0, c0, w0;
    for (int i = 0; i < (1 << AW); i++) begin
      vram[i]   = 8'($urandom_range(0, 255));
      shadow[i] = vram[i];
    end
    vram[14'h0100]   = 8'h3C;
    shadow[14'h0100] = 8'h3C;
    mem_rdata = 8'h00;
    idle();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    repeat (3) step();
    rst_n = 1;
    step();

    // back-to-back writes with the VDP idle drain one per cycle
    peak = 0;
    for (int i = 0; i < 4; i++) begin
      cpu_wr_req  = 1;
      cpu_wr_addr = AW'(i);
      cpu_wr_data = 8'(8'hA0 + i);
      step();
    end
    idle();
    repeat (3) step();
    for (int i = 0; i < 4; i++) check("s1_vram", vram[i], 32'hA0 + i);
    check("s1_peak_le1", peak <= 1, 1);

    // VDP hogs the port: buffer fills at 4, fifth write refused
    keep    = vram[14'h0014];
    vdp_req = 1;
    for (int i = 0; i < 5; i++) begin
      cpu_wr_req  = 1;
      cpu_wr_addr = AW'(16 + i);
      cpu_wr_data = 8'(8'hB0 + i);
      step();
    end
    cpu_wr_req = 0;
    #1;
    check("s2_level_full", wbuf_level, 4);
    check("s2_ready_low", cpu_wr_ready, 0);
    vdp_req = 0;
    repeat (6) step();
    for (int i = 0; i < 4; i++) check("s2_vram", vram[16 + i], 32'hB0 + i);
    check("s2_fifth_dropped", vram[14'h0014], keep);

    // read-after-write: the read sees the posted write
    vdp_req     = 1;
    cpu_wr_req  = 1;
    cpu_wr_addr = 14'h1234;
    cpu_wr_data = 8'h55;
    step();
    cpu_wr_req  = 0;
    cpu_rd_req  = 1;
    cpu_rd_addr = 14'h1234;
    repeat (3) step();
    vdp_req = 0;
    wait_ack("s3_ack", 20);
    cpu_rd_req = 0;
    check("s3_rd_data", cpu_rd_data, 8'h55);
    repeat (2) step();

    // idle read: minimum latency, request held through the ack cycle
    cpu_rd_req  = 1;
    cpu_rd_addr = 14'h0100;
    c0 = cyc;
    n0 = ack_count;
    wait_ack("s4_ack", 10);
    check("s4_latency", ack_cyc - c0, 3);
    check("s4_rd_data", cpu_rd_data, 8'h3C);
    cpu_rd_req = 0;
    repeat (6) step();
    check("s4_single_ack", ack_count - n0, 1);

    // starvation: flag sets, clear loses while starved, clear wins afterwards
    vdp_req     = 1;
    cpu_rd_req  = 1;
    cpu_rd_addr = 14'h0200;
    repeat (10) step();
    #1;
    check("s5_flag_set", starve_flag, 1);
    starve_clr = 1;
    step();
    starve_clr = 0;
    #1;
    check("s5_set_wins", starve_flag, 1);
    vdp_req = 0;
    wait_ack("s5_ack", 10);
    cpu_rd_req = 0;
    starve_clr = 1;
    step();
    starve_clr = 0;
    #1;
    check("s5_flag_clr", starve_flag, 0);
    step();

    // reset during RD_WAIT with buffered writes
    vdp_req = 1;
    for (int i = 0; i < 3; i++) begin
      cpu_wr_req  = 1;
      cpu_wr_addr = AW'(14'h0300 + i);
      cpu_wr_data = 8'(8'hC0 + i);
      step();
    end
    cpu_wr_req  = 0;
    cpu_rd_req  = 1;
    cpu_rd_addr = 14'h0300;
    repeat (2) step();
    n0 = ack_count;
    w0 = we_count;
    rst_n = 0;
    #1;
    check("s6_level", wbuf_level, 0);
    check("s6_ready", cpu_wr_ready, 1);
    step();
    rst_n      = 1;
    cpu_rd_req = 0;
    vdp_req    = 0;
    repeat (8) step();
    check("s6_no_ack", ack_count - n0, 0);
    check("s6_no_we", we_count - w0, 0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n       = ($urandom_range(0, 499) != 0);
      vdp_req     = ($urandom_range(0, 99) < 55);
      vdp_addr    = AW'($urandom_range(0, (1 << AW) - 1));
      cpu_wr_req  = ($urandom_range(0, 99) < 35);
      cpu_wr_addr = AW'($urandom_range(0, 255));
      cpu_wr_data = 8'($urandom_range(0, 255));
      starve_clr  = ($urandom_range(0, 19) == 0);
      if (cpu_rd_req) begin
        if (ack_last || (m_wait && $urandom_range(0, 29) == 0)) cpu_rd_req = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        cpu_rd_req  = 1;
        cpu_rd_addr = AW'($urandom_range(0, 255));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
